// File: rtl/rob_nwide_pkg.sv
// Shared types for the N-wide reorder buffer: entry layout and the modulo-age
// liveness test used for completions and mispredict recovery.
package rob_nwide_pkg;

    // Entry fields are sized for the widest supported configuration; narrower
    // instances cast on the way in and out.
    localparam int ROB_PREG_W_MAX = 16;
    localparam int ROB_PC_W_MAX   = 64;

    typedef struct packed {
        logic                      valid;
        logic                      done;
        logic                      has_dest;
        logic [ROB_PREG_W_MAX-1:0] pd_new;
        logic [ROB_PREG_W_MAX-1:0] pd_old;
        logic [ROB_PC_W_MAX-1:0]   pc;
    } rob_entry_t;

    // A tag is live when its distance from head is below the occupancy;
    // pointers carry the wrap bit, depth must be a power of two.
    function automatic logic rob_is_live(input int unsigned tag,
                                         input int unsigned head_ptr,
                                         input int unsigned tail_ptr,
                                         input int unsigned depth);
        int unsigned off;
        int unsigned occ;
        off = (tag - head_ptr) & (depth - 1);
        occ = (tail_ptr - head_ptr) & (2 * depth - 1);
        return off < occ;
    endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Picks the contiguous run of retirable head entries and its length.
module rob_retire_sel #(
    parameter  int RETIRE_W = 2,
    localparam int CNT_W    = $clog2(RETIRE_W + 1)
) (
    input  logic [RETIRE_W-1:0] valid,
    input  logic [RETIRE_W-1:0] done,
    output logic [RETIRE_W-1:0] mask,
    output logic [CNT_W-1:0]    cnt
);

    logic run;

    always_comb begin
        mask = '0;
        cnt  = '0;
        run  = 1'b1;
        for (int k = 0; k < RETIRE_W; k++) begin
            run     = run & valid[k] & done[k];
            mask[k] = run;
            cnt     = cnt + CNT_W'(run);
        end
    end

endmodule

// File: rtl/rob_nwide.sv
// Reorder buffer with N completion ports, up to RETIRE_W in-order retirements
// per cycle and age-checked mispredict truncation with a registered flush.
module rob_nwide
    import rob_nwide_pkg::*;
#(
    parameter  int DEPTH    = 32,
    parameter  int NUM_WB   = 3,
    parameter  int RETIRE_W = 2,
    parameter  int PREG_W   = 7,
    parameter  int PC_W     = 32,
    localparam int TAG_W    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [PREG_W-1:0]          alloc_pd_new,
    input  logic [PREG_W-1:0]          alloc_pd_old,
    input  logic                       alloc_has_dest,
    input  logic [PC_W-1:0]            alloc_pc,
    output logic [TAG_W-1:0]           alloc_tag,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
    input  logic                       br_mispredict,
    input  logic [TAG_W-1:0]           br_tag,
    input  logic [PC_W-1:0]            br_target_pc,
    output logic                       flush,
    output logic [TAG_W-1:0]           flush_tag,
    output logic [PC_W-1:0]            flush_pc,
    output logic [RETIRE_W-1:0]        retire_valid,
    output logic [RETIRE_W-1:0]        retire_has_dest,
    output logic [RETIRE_W*PREG_W-1:0] retire_pd_old,
    output logic [TAG_W-1:0]           head,
    output logic [TAG_W:0]             count,
    output logic                       full,
    output logic                       empty
);

    localparam int CNT_W = $clog2(RETIRE_W + 1);

    rob_entry_t         mem [DEPTH];
    logic [TAG_W:0]     head_ptr_reg, tail_ptr_reg, occ;
    logic [TAG_W-1:0]   head_idx, tail_idx, br_off;
    logic               flush_reg;
    logic [TAG_W-1:0]   flush_tag_reg;
    logic [PC_W-1:0]    flush_pc_reg;
    logic               br_take, alloc_fire;
    logic [RETIRE_W-1:0] slot_valid, slot_done, ret_mask;
    logic [TAG_W-1:0]   slot_idx [RETIRE_W];
    logic [CNT_W-1:0]   ret_cnt;
    logic [TAG_W-1:0]   ent_off [DEPTH];
    logic [DEPTH-1:0]   ent_live, kill, done_set;

    assign head_idx    = head_ptr_reg[TAG_W-1:0];
    assign tail_idx    = tail_ptr_reg[TAG_W-1:0];
    assign occ         = tail_ptr_reg - head_ptr_reg;
    assign empty       = (head_ptr_reg == tail_ptr_reg);
    assign full        = (head_idx == tail_idx) && (head_ptr_reg[TAG_W] != tail_ptr_reg[TAG_W]);
    assign count       = occ;
    assign head        = head_idx;
    assign alloc_tag   = tail_idx;
    assign alloc_ready = !full && !br_mispredict;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign br_off      = br_tag - head_idx;
    assign br_take     = br_mispredict &&
                         rob_is_live(32'(br_tag), 32'(head_ptr_reg), 32'(tail_ptr_reg), DEPTH);

    assign flush     = flush_reg;
    assign flush_tag = flush_tag_reg;
    assign flush_pc  = flush_pc_reg;

    // Head window; slots younger than a mispredicting branch must not retire
    // on the edge that truncates them.
    for (genvar gi = 0; gi < RETIRE_W; gi++) begin : g_slot
        assign slot_idx[gi]    = head_idx + TAG_W'(gi);
        assign slot_valid[gi]  = mem[slot_idx[gi]].valid && !(br_take && (TAG_W'(gi) > br_off));
        assign slot_done[gi]   = mem[slot_idx[gi]].done;
        assign retire_has_dest[gi] = ret_mask[gi] && mem[slot_idx[gi]].has_dest;
        assign retire_pd_old[gi*PREG_W +: PREG_W] = PREG_W'(mem[slot_idx[gi]].pd_old);
    end

    rob_retire_sel #(.RETIRE_W(RETIRE_W)) u_retire_sel (
        .valid (slot_valid),
        .done  (slot_done),
        .mask  (ret_mask),
        .cnt   (ret_cnt)
    );
    assign retire_valid = ret_mask;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [NUM_WB-1:0] hit;
        assign ent_off[gi]  = TAG_W'(gi) - head_idx;
        assign ent_live[gi] = ({1'b0, ent_off[gi]} < occ);
        assign kill[gi]     = br_take && ent_live[gi] && (ent_off[gi] > br_off);
        for (genvar pi = 0; pi < NUM_WB; pi++) begin : g_port
            assign hit[pi] = wb_valid[pi] && (wb_tag[pi*TAG_W +: TAG_W] == TAG_W'(gi));
        end
        assign done_set[gi] = (|hit) && ent_live[gi] && mem[gi].valid && !kill[gi];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_ptr_reg  <= '0;
            tail_ptr_reg  <= '0;
            flush_reg     <= 1'b0;
            flush_tag_reg <= '0;
            flush_pc_reg  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                mem[j].valid <= 1'b0;
                mem[j].done  <= 1'b0;
            end
        end else begin
            flush_reg <= br_take;
            if (br_take) begin
                flush_tag_reg <= br_tag;
                flush_pc_reg  <= br_target_pc;
                tail_ptr_reg  <= head_ptr_reg + (TAG_W+1)'(br_off) + (TAG_W+1)'(1);
            end else if (alloc_fire) begin
                tail_ptr_reg <= tail_ptr_reg + (TAG_W+1)'(1);
            end
            head_ptr_reg <= head_ptr_reg + (TAG_W+1)'(ret_cnt);

            for (int j = 0; j < DEPTH; j++) begin
                if (kill[j]) begin
                    mem[j].valid <= 1'b0;
                    mem[j].done  <= 1'b0;
                end else if (alloc_fire && (tail_idx == TAG_W'(j))) begin
                    mem[j] <= '{valid:    1'b1,
                                done:     1'b0,
                                has_dest: alloc_has_dest,
                                pd_new:   ROB_PREG_W_MAX'(alloc_pd_new),
                                pd_old:   ROB_PREG_W_MAX'(alloc_pd_old),
                                pc:       ROB_PC_W_MAX'(alloc_pc)};
                end else if (done_set[j] || (br_take && (br_tag == TAG_W'(j)))) begin
                    mem[j].done <= 1'b1;
                end
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                if (ret_mask[k]) begin
                    mem[slot_idx[k]].valid <= 1'b0;
                    mem[slot_idx[k]].done  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_nwide.sv
// Randomised scoreboard bench for rob_nwide: a queue-based program-order model
// predicts status, retirements and flushes; a monitor compares each cycle.
module tb_rob_nwide;

    localparam int DEPTH  = 32;
    localparam int NUM_WB = 3;
    localparam int RW     = 2;
    localparam int PREG_W = 7;
    localparam int PC_W   = 32;
    localparam int TAG_W  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset = 1'b0;
    logic                    alloc_valid = 1'b0, alloc_ready, alloc_has_dest = 1'b0;
    logic [PREG_W-1:0]       alloc_pd_new = '0, alloc_pd_old = '0;
    logic [PC_W-1:0]         alloc_pc = '0;
    logic [TAG_W-1:0]        alloc_tag;
    logic [NUM_WB-1:0]       wb_valid = '0;
    logic [NUM_WB*TAG_W-1:0] wb_tag = '0;
    logic                    br_mispredict = 1'b0;
    logic [TAG_W-1:0]        br_tag = '0;
    logic [PC_W-1:0]         br_target_pc = '0;
    logic                    flush;
    logic [TAG_W-1:0]        flush_tag;
    logic [PC_W-1:0]         flush_pc;
    logic [RW-1:0]           retire_valid, retire_has_dest;
    logic [RW*PREG_W-1:0]    retire_pd_old;
    logic [TAG_W-1:0]        head;
    logic [TAG_W:0]          count;
    logic                    full, empty;

    rob_nwide #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .RETIRE_W(RW), .PREG_W(PREG_W), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
        .alloc_has_dest(alloc_has_dest), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .br_mispredict(br_mispredict), .br_tag(br_tag), .br_target_pc(br_target_pc),
        .flush(flush), .flush_tag(flush_tag), .flush_pc(flush_pc),
        .retire_valid(retire_valid), .retire_has_dest(retire_has_dest),
        .retire_pd_old(retire_pd_old),
        .head(head), .count(count), .full(full), .empty(empty)
    );

    typedef struct { bit done; bit hd; logic [PREG_W-1:0] pdo; } ment_t;
    typedef struct { int cyc; bit hd; logic [PREG_W-1:0] pdo; } ret_t;
    typedef struct { int cyc; logic [TAG_W-1:0] tag; logic [PC_W-1:0] pc; } fl_t;
    typedef struct { int cyc; int cnt; int hidx; int tidx; bit rdy; } st_t;

    ment_t mq[$];
    ret_t  rt_q[$];
    fl_t   fl_q[$];
    st_t   st_q[$];
    int    mh = 0;
    int    cyc = 0;
    bit    armed = 1'b0;
    int    checks = 0;
    int    errors = 0;
    logic [PC_W-1:0] pc_ctr = '0;

    // Next-cycle stimulus, applied by tick() and then returned to idle.
    bit                      n_rst = 1'b1, n_av = 1'b0, n_hd = 1'b0, n_br = 1'b0;
    logic [PREG_W-1:0]       n_pdo = '0;
    logic [NUM_WB-1:0]       n_wbv = '0;
    logic [NUM_WB*TAG_W-1:0] n_wbt = '0;
    logic [TAG_W-1:0]        n_brt = '0;
    logic [PC_W-1:0]         n_brpc = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int sz, pos, lim, nret, ofs;
        bit live, acc;
        sz = mq.size();
        cyc++;
        if (armed) st_q.push_back('{cyc, sz, mh, (mh + sz) % DEPTH, (sz < DEPTH) && !n_br});
        live = 1'b0;
        pos  = 0;
        if (n_br) begin
            pos  = (int'(n_brt) - mh + DEPTH) % DEPTH;
            live = pos < sz;
        end
        lim = RW;
        if (live && pos + 1 < lim) lim = pos + 1;
        nret = 0;
        while (nret < lim && nret < sz && mq[nret].done) nret++;
        if (armed) for (int i = 0; i < nret; i++) rt_q.push_back('{cyc, mq[i].hd, mq[i].pdo});
        acc = n_av && (sz < DEPTH) && !n_br;
        if (!n_rst) begin
            mq.delete();
            mh    = 0;
            armed = 1'b1;
            return;
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (n_wbv[p]) begin
                ofs = (int'(n_wbt[p*TAG_W +: TAG_W]) - mh + DEPTH) % DEPTH;
                if (ofs < sz && !(live && ofs > pos)) mq[ofs].done = 1'b1;
            end
        end
        if (live) begin
            while (mq.size() > pos + 1) void'(mq.pop_back());
            mq[pos].done = 1'b1;
            fl_q.push_back('{cyc + 1, n_brt, n_brpc});
        end
        for (int i = 0; i < nret; i++) void'(mq.pop_front());
        mh = (mh + nret) % DEPTH;
        if (acc) begin
            mq.push_back('{1'b0, n_hd, n_pdo});
            pc_ctr = pc_ctr + 32'd4;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        reset          = n_rst;
        alloc_valid    = n_av;
        alloc_has_dest = n_hd;
        alloc_pd_old   = n_pdo;
        alloc_pd_new   = ~n_pdo;
        alloc_pc       = pc_ctr;
        wb_valid       = n_wbv;
        wb_tag         = n_wbt;
        br_mispredict  = n_br;
        br_tag         = n_brt;
        br_target_pc   = n_brpc;
        model_step();
        n_rst = 1'b1; n_av = 1'b0; n_wbv = '0; n_br = 1'b0;
    endtask

    task automatic alloc_one();
        n_av  = 1'b1;
        n_hd  = 1'($urandom);
        n_pdo = PREG_W'($urandom);
        tick();
    endtask

    task automatic set_wb(input int p, input int t);
        n_wbv[p] = 1'b1;
        n_wbt[p*TAG_W +: TAG_W] = TAG_W'(t);
    endtask

    // Completes up to NUM_WB outstanding entries per cycle until empty.
    task automatic drain();
        int p;
        for (int c = 0; c < 200 && mq.size() > 0; c++) begin
            p = 0;
            for (int i = 0; i < mq.size() && p < NUM_WB; i++) begin
                if (!mq[i].done) begin
                    set_wb(p, (mh + i) % DEPTH);
                    p++;
                end
            end
            tick();
        end
        chk("drain_empty", mq.size(), 0);
        repeat (2) tick();
    endtask

    always @(negedge clk) begin
        st_t st;
        fl_t f;
        ret_t r;
        bit  exp_f, exp_r;
        #2;
        if (st_q.size() > 0) begin
            st = st_q.pop_front();
            chk("status_cycle", st.cyc, cyc);
            chk("count", 32'(count), st.cnt);
            chk("head", 32'(head), st.hidx);
            chk("alloc_tag", 32'(alloc_tag), st.tidx);
            chk("alloc_ready", 32'(alloc_ready), 32'(st.rdy));
            chk("empty", 32'(empty), 32'(st.cnt == 0));
            chk("full", 32'(full), 32'(st.cnt == DEPTH));
            for (int k = 0; k < RW; k++) begin
                exp_r = (rt_q.size() > 0) && (rt_q[0].cyc == st.cyc);
                chk($sformatf("retire_valid%0d", k), 32'(retire_valid[k]), 32'(exp_r));
                if (exp_r) begin
                    r = rt_q.pop_front();
                    if (retire_valid[k]) begin
                        chk("retire_has_dest", 32'(retire_has_dest[k]), 32'(r.hd));
                        chk("retire_pd_old", 32'(retire_pd_old[k*PREG_W +: PREG_W]), 32'(r.pdo));
                        $display("cycle %0d retire slot %0d pd_old %0d has_dest %0d",
                                 cyc, k, r.pdo, r.hd);
                    end
                end
            end
            exp_f = (fl_q.size() > 0) && (fl_q[0].cyc == st.cyc);
            chk("flush", 32'(flush), 32'(exp_f));
            if (exp_f) begin
                f = fl_q.pop_front();
                if (flush) begin
                    chk("flush_tag", 32'(flush_tag), 32'(f.tag));
                    chk("flush_pc", 32'(flush_pc), 32'(f.pc));
                    $display("cycle %0d flush tag %0d pc 0x%08h", cyc, f.tag, f.pc);
                end
            end
        end
    end

    initial begin
        int sz, t;
        // Reset held for two cycles; the second cycle checks reset values.
        n_rst = 1'b0; tick();
        n_rst = 1'b0; tick();

        // Four allocs get tags 0..3, nothing retires before completion.
        repeat (4) alloc_one();
        tick();
        set_wb(0, 1); set_wb(1, 0); tick();
        repeat (2) tick();
        set_wb(0, 3); tick();
        repeat (2) tick();
        set_wb(0, 2); tick();
        repeat (2) tick();

        // Fill to full, attempt dropped allocs, free two, wrap-around allocs.
        while (mq.size() < DEPTH) alloc_one();
        repeat (2) alloc_one();
        set_wb(0, mh); set_wb(1, (mh + 1) % DEPTH); tick();
        tick();
        repeat (2) alloc_one();
        tick();
        drain();

        // Mispredict on tag 5 of 0..9, then a completion to a flushed tag.
        n_rst = 1'b0; tick();
        repeat (10) alloc_one();
        n_br = 1'b1; n_brt = 5'd5; n_brpc = 32'h40; tick();
        set_wb(0, 8); alloc_one();
        repeat (2) tick();
        drain();

        // Mispredict coincident with retirement of tags 0,1 and an alloc attempt.
        n_rst = 1'b0; tick();
        repeat (8) alloc_one();
        set_wb(0, 0); set_wb(1, 1); tick();
        n_br = 1'b1; n_brt = 5'd5; n_brpc = 32'h1234; n_av = 1'b1; tick();
        repeat (2) tick();

        // Mispredict on a tag outside the window is ignored.
        n_br = 1'b1; n_brt = TAG_W'((mh + mq.size() + 3) % DEPTH); n_brpc = 32'hdead; tick();
        repeat (2) tick();

        // Reset in the middle of traffic.
        repeat (3) alloc_one();
        set_wb(0, mh); n_rst = 1'b0; tick();
        repeat (2) tick();

        for (int c = 0; c < 3000; c++) begin
            sz    = mq.size();
            n_av  = ($urandom_range(0, 99) < 65);
            n_hd  = 1'($urandom);
            n_pdo = PREG_W'($urandom);
            for (int p = 0; p < NUM_WB; p++) begin
                if ($urandom_range(0, 99) < 50) begin
                    if (sz > 0 && $urandom_range(0, 9) < 8) t = (mh + int'($urandom_range(0, sz - 1))) % DEPTH;
                    else t = int'($urandom_range(0, DEPTH - 1));
                    set_wb(p, t);
                end
            end
            if ($urandom_range(0, 99) < 4) begin
                n_br = 1'b1;
                if (sz > 0 && $urandom_range(0, 9) < 8) n_brt = TAG_W'((mh + int'($urandom_range(0, sz - 1))) % DEPTH);
                else n_brt = TAG_W'($urandom);
                n_brpc = $urandom;
            end
            if ($urandom_range(0, 999) < 4) begin
                n_rst = 1'b0; n_br = 1'b0; n_av = 1'b0;
            end
            tick();
        end
        drain();
        repeat (2) tick();
        #5;
        chk("retire_queue_left", rt_q.size(), 0);
        chk("flush_queue_left", fl_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_nwide.md
Name: rob_nwide

Overview:
Parametrised reorder buffer, the successor to the single-retire ROB. It sits between dispatch, the FU completion buses, rename (free-list return) and the checkpoint/PRF recovery logic. It adds configurable depth, N completion ports and up to RETIRE_W in-order retirements per cycle. It also adds age-checked branch-mispredict truncation with a registered flush broadcast.

Parameters:
DEPTH, 32, number of entries; power of two, >=4
NUM_WB, 3, completion ports (ALU, branch, mem)
RETIRE_W, 2, max retirements per cycle; 1..4
PREG_W, 7, physical register index width
PC_W, 32, PC width
TAG_W, $clog2(DEPTH), derived ROB tag width; not overridable

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 clears state at posedge clk)
alloc_valid  in  1  dispatch presents an instruction
alloc_ready  out  1  = !full && !br_mispredict
alloc_pd_new  in  PREG_W  new destination preg
alloc_pd_old  in  PREG_W  previous mapping of rd
alloc_has_dest  in  1  instruction writes rd
alloc_pc  in  PC_W  instruction PC
alloc_tag  out  TAG_W  tag given to the current alloc (tail index)
wb_valid  in  NUM_WB  completion strobes
wb_tag  in  NUM_WB*TAG_W  completion tags, port i at [i*TAG_W +: TAG_W]
br_mispredict  in  1  branch FU resolved mispredict
br_tag  in  TAG_W  ROB tag of the mispredicting branch
br_target_pc  in  PC_W  correct PC
flush  out  1  one-cycle recovery pulse
flush_tag  out  TAG_W  tag of the surviving youngest (branch)
flush_pc  out  PC_W  redirect PC
retire_valid  out  RETIRE_W  bit k: k-th oldest retires this cycle (contiguous from bit 0)
retire_has_dest  out  RETIRE_W  per-slot rd-writes flag
retire_pd_old  out  RETIRE_W*PREG_W  per-slot preg to free
head  out  TAG_W  oldest entry index
count  out  TAG_W+1  occupied entries
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- State: per entry valid, done, has_dest, pd_new, pd_old, pc. head_ptr/tail_ptr are TAG_W+1 bits, with the MSB as the wrap bit. full/empty come from the pointer compare. count = tail_ptr - head_ptr.
- Reset (reset==0 at edge): all valid/done=0, pointers=0. Outputs: flush=0, flush_tag=0, flush_pc=0, retire_valid=0, count=0, empty=1, full=0, alloc_ready=1.
- Alloc: on alloc_valid && alloc_ready, the entry at tail is written with valid=1, done=0, and tail advances by 1. alloc_tag = tail index combinationally. The entry is visible the next cycle.
- Completion: for each port with wb_valid[i], set done if entry valid and the tag is live (head <= tag < tail, modulo-age compare). Otherwise ignore. Multiple ports to the same tag are harmless.
- Retire (combinational select, registered effect): slot k retires iff entries head..head+k are all valid && done and k < RETIRE_W. The first non-done entry stops the scan. retire_* outputs are combinational from the head entries. At the edge, retired entries are cleared and head advances by the popcount.
- Completions arriving this cycle do not retire this cycle; latency is done-set edge, then retire the next cycle.
- Mispredict: when br_mispredict is high and br_tag is live, then at the edge:
  - tail = br_tag+1 (with correct wrap bit)
  - valid cleared for all entries younger than br_tag
  - br_tag entry marked done
  - flush registered high for one cycle, with flush_tag=br_tag and flush_pc=br_target_pc
- Alloc is blocked in the mispredict cycle (alloc_ready=0). A non-live br_tag is ignored (no flush).
- Simultaneous events:
  - Retire and mispredict on the same edge: both apply; head moves, and tail truncation is independent.
  - A completion to a tag flushed on the same edge is dropped.
  - Alloc with full=1 is dropped and state is unchanged.
  - Retire of the last entry plus an alloc on the same edge: count stays consistent.
- Wrap-around: all age compares use the pointer wrap bit. Index DEPTH-1 to 0 is transparent.
- Reset mid-operation dominates every other event.

Decomposition:
- types_pkg gains rob_entry_t (valid, done, has_dest, pd_new, pd_old, pc) and a function rob_is_live(tag, head_ptr, tail_ptr).
- One sub-module: rob_retire_sel. It is combinational and takes valid/done of the RETIRE_W head entries, returning the contiguous retire mask and popcount.
- Storage stays in rob_nwide.

Test Plan:
1. Reset low 2 cycles, then alloc 4 instrs (pcs 0,4,8,12) -> tags 0..3, count=4, retire_valid=0 until completions.
2. Complete tags 1,0 on ports 0,1 in the same cycle -> next cycle retire_valid=2'b11, pd_old of tags 0,1, head=2. Completing tag 3 only -> no retire (tag 2 blocks).
3. Fill 32 entries -> full=1, alloc_ready=0. A 33rd alloc is dropped. Retire 2 -> full=0. New allocs get tags 0,1 (wrap) and count=32.
4. Tags 0..9 allocated, br_mispredict br_tag=5 pc=0x40 -> next cycle flush=1, flush_tag=5, flush_pc=0x40. Next alloc_tag=6 and count=6 (if none retired). wb to tag 8 is ignored.
5. Mispredict edge coincident with retire of tags 0,1 and alloc_valid -> head=2, tail=br_tag+1, alloc not written.
6. br_tag outside [head,tail) with br_mispredict=1 -> no flush and pointers unchanged. reset=0 asserted mid-stream -> all outputs at reset values next cycle.
